// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: oversampled start detection, 3-sample majority vote per bit,
// optional parity and stop checking, single-cycle result strobes.
module uart_rx_deserializer #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                  state, state_next;
    logic                    rx_meta, rx_s;
    logic [PRESCALE_W-1:0]   edge_cnt, presc, half;
    logic [BIT_W-1:0]        bit_cnt;
    logic                    par_en_l, par_typ_l, par_bad;
    logic [2:0]              smp;
    logic                    vote, last_tick;
    logic [DATA_WIDTH-1:0]   shift;

    assign half      = presc >> 1;
    assign last_tick = (edge_cnt == presc - PRESCALE_W'(1));
    assign vote      = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX_IN;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!rx_s) state_next = START;
            START:   if (last_tick) state_next = vote ? IDLE : DATA;
            DATA:    if (last_tick && bit_cnt == LAST_BIT)
                         state_next = par_en_l ? PARITY : STOP;
            PARITY:  if (last_tick) state_next = STOP;
            STOP:    if (last_tick) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            presc      <= '0;
            par_en_l   <= 1'b0;
            par_typ_l  <= 1'b0;
            par_bad    <= 1'b0;
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            if (state == IDLE) begin
                // The detection cycle is tick 0, so the frame continues at tick 1.
                edge_cnt <= rx_s ? '0 : PRESCALE_W'(1);
                if (!rx_s) begin
                    presc     <= Prescale;
                    par_en_l  <= PAR_EN;
                    par_typ_l <= PAR_TYP;
                    par_bad   <= 1'b0;
                end
            end else begin
                edge_cnt <= last_tick ? '0 : edge_cnt + PRESCALE_W'(1);
                if (edge_cnt == half - PRESCALE_W'(1)) smp[0] <= rx_s;
                if (edge_cnt == half)                  smp[1] <= rx_s;
                if (edge_cnt == half + PRESCALE_W'(1)) smp[2] <= rx_s;
                if (last_tick) begin
                    case (state)
                        START: bit_cnt <= '0;
                        DATA: begin
                            shift[bit_cnt] <= vote;
                            bit_cnt        <= bit_cnt + BIT_W'(1);
                        end
                        PARITY: par_bad <= (vote != ((^shift) ^ par_typ_l));
                        STOP: begin
                            if (vote && !par_bad) begin
                                P_DATA     <= shift;
                                data_valid <= 1'b1;
                            end else begin
                                par_err <= par_bad;
                                stp_err <= ~vote;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: drives whole frames cycle by cycle and checks
// strobe timing, payload and error reporting against hand-computed values.
module tb_uart_rx_deserializer;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RX_IN = 1'b1;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [5:0] Prescale = 6'd8;
    logic [7:0] P_DATA;
    logic       data_valid, par_err, stp_err;

    uart_rx_deserializer #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
        .Prescale(Prescale), .P_DATA(P_DATA), .data_valid(data_valid),
        .par_err(par_err), .stp_err(stp_err)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Strobe history, sampled on the falling edge.
    int         vcount = 0, pcount = 0, scount = 0;
    int         pcyc = 0, scyc = 0;
    int         vcyc[32];
    logic [7:0] vdat[32];

    always @(negedge CLK) begin
        if (data_valid) begin
            if (vcount < 32) begin
                vcyc[vcount] = cyc;
                vdat[vcount] = P_DATA;
            end
            vcount++;
        end
        if (par_err) begin
            pcount++;
            pcyc = cyc;
        end
        if (stp_err) begin
            scount++;
            scyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            RX_IN = 1'b1;
            RST   = 1'b0;
        end
    endtask

    // Drives one frame; glitch_off inverts the line for one cycle, rst_off pulses RST.
    task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                              input logic pbit, input logic sbit, input int p,
                              input int glitch_off, input int rst_off, output int t0);
        int   n;
        int   b;
        logic v;
        n  = pen ? 11 : 10;
        t0 = 0;
        for (int i = 0; i < n * p; i++) begin
            @(negedge CLK);
            if (i == 0) begin
                t0       = cyc;
                PAR_EN   = pen;
                PAR_TYP  = ptyp;
                Prescale = 6'(p);
            end
            b = i / p;
            if (b == 0)               v = 1'b0;
            else if (b <= 8)          v = d[b-1];
            else if (b == 9 && pen)   v = pbit;
            else                      v = sbit;
            if (i == glitch_off) v = ~v;
            RX_IN = v;
            RST   = (i == rst_off);
        end
    endtask

    int t0, t1, vb, pb, sb;

    initial begin
        repeat (3) @(negedge CLK);
        check("rst_p_data", P_DATA, 0);
        check("rst_valid", data_valid, 0);
        check("rst_par_err", par_err, 0);
        check("rst_stp_err", stp_err, 0);
        idle(10);

        // P=8, no parity, 0xA5
        vb = vcount; pb = pcount; sb = scount;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8, -1, -1, t0);
        idle(10);
        check("a5_count", vcount - vb, 1);
        check("a5_cycle", vcyc[vb], t0 + 2 + 80);
        check("a5_data", vdat[vb], 8'hA5);
        check("a5_no_err", (pcount - pb) + (scount - sb), 0);

        // P=16, parity even then odd, both correct
        vb = vcount; pb = pcount;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 16, -1, -1, t0);
        idle(5);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 16, -1, -1, t1);
        idle(10);
        check("par_ok_count", vcount - vb, 2);
        check("par_even_cycle", vcyc[vb], t0 + 2 + 176);
        check("par_odd_cycle", vcyc[vb+1], t1 + 2 + 176);
        check("par_ok_data", vdat[vb+1], 8'h3C);
        check("par_ok_no_err", pcount - pb, 0);

        // P=8, even parity expected 1, sent 0
        vb = vcount; pb = pcount; sb = scount;
        send_frame(8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 8, -1, -1, t0);
        idle(10);
        check("par_bad_count", pcount - pb, 1);
        check("par_bad_cycle", pcyc, t0 + 2 + 88);
        check("par_bad_no_valid", vcount - vb, 0);
        check("par_bad_hold", P_DATA, 8'h3C);
        check("par_bad_no_stp", scount - sb, 0);

        // Stop bit low, no parity
        vb = vcount; pb = pcount; sb = scount;
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 8, -1, -1, t0);
        idle(20);
        check("stp_count", scount - sb, 1);
        check("stp_cycle", scyc, t0 + 2 + 80);
        check("stp_no_valid", vcount - vb, 0);
        check("stp_no_par", pcount - pb, 0);

        // Bad parity and bad stop together
        vb = vcount; pb = pcount; sb = scount;
        send_frame(8'h55, 1'b1, 1'b0, 1'b1, 1'b0, 8, -1, -1, t0);
        idle(20);
        check("both_par_cycle", pcyc, t0 + 2 + 88);
        check("both_stp_cycle", scyc, t0 + 2 + 88);
        check("both_counts", (pcount - pb) * 16 + (scount - sb), 17);
        check("both_no_valid", vcount - vb, 0);

        // Short low glitch from idle, then a real frame
        vb = vcount; pb = pcount; sb = scount;
        repeat (3) begin
            @(negedge CLK);
            RX_IN = 1'b0;
        end
        idle(40);
        check("glitch_no_strobe", (vcount - vb) + (pcount - pb) + (scount - sb), 0);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 16, -1, -1, t0);
        idle(10);
        check("after_glitch_count", vcount - vb, 1);
        check("after_glitch_data", vdat[vb], 8'h81);
        check("after_glitch_cycle", vcyc[vb], t0 + 2 + 160);

        // Inverted middle sample of data bit 3
        vb = vcount;
        send_frame(8'hF7, 1'b0, 1'b0, 1'b0, 1'b1, 16, 4 * 16 + 8, -1, t0);
        idle(10);
        check("vote_count", vcount - vb, 1);
        check("vote_data", vdat[vb], 8'hF7);

        // Back-to-back at P=32
        vb = vcount; pb = pcount; sb = scount;
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 32, -1, -1, t0);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 32, -1, -1, t1);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 32, -1, -1, t1);
        idle(10);
        check("b2b_count", vcount - vb, 3);
        check("b2b_first_cycle", vcyc[vb], t0 + 2 + 320);
        check("b2b_gap1", vcyc[vb+1] - vcyc[vb], 320);
        check("b2b_gap2", vcyc[vb+2] - vcyc[vb+1], 320);
        check("b2b_data0", vdat[vb], 8'h00);
        check("b2b_data1", vdat[vb+1], 8'hFF);
        check("b2b_data2", vdat[vb+2], 8'h5A);
        check("b2b_no_err", (pcount - pb) + (scount - sb), 0);

        // Reset during data bits aborts the frame
        vb = vcount; pb = pcount; sb = scount;
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 8, -1, 3 * 8 + 2, t0);
        idle(20);
        check("rst_mid_no_strobe", (vcount - vb) + (pcount - pb) + (scount - sb), 0);
        check("rst_mid_p_data", P_DATA, 0);
        send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b1, 8, -1, -1, t0);
        idle(10);
        check("rst_next_count", vcount - vb, 1);
        check("rst_next_data", vdat[vb], 8'h96);
        check("rst_next_cycle", vcyc[vb], t0 + 2 + 80);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
